// File: rtl/quire_pkg.sv
// Quire geometry and FSM encoding shared by the bank writer and its splitter.
// Eight 80-bit entries: 64 data bits plus 16 carry-guard bits each.
package quire_pkg;
    localparam int QUIRE_BLOCKS = 8;
    localparam int BLK_W        = 64;
    localparam int GUARD_W      = 16;
    localparam int ENTRY_W      = 80;
    localparam int BANK_ADR_W   = 2;
    localparam int SHIFT_W      = 9;
    localparam int CNT_W        = 15;

    typedef logic [ENTRY_W-1:0]    entry_t;
    typedef logic [BANK_ADR_W-1:0] badr_t;

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_ACC,
        ST_DRAIN,
        ST_DONE
    } state_t;
endpackage

// File: rtl/quire_split.sv
// Shifts a product into quire position, splits it across the two banks
// and applies the sign; flags a nonzero high part that falls off block 7.
module quire_split
    import quire_pkg::*;
(
    input  logic               i_sign,
    input  logic [BLK_W-1:0]   i_frac,
    input  logic [SHIFT_W-1:0] i_shift,
    output entry_t             o_part_even,
    output entry_t             o_part_odd,
    output badr_t              o_adr_even,
    output badr_t              o_adr_odd,
    output logic               o_en_even,
    output logic               o_en_odd,
    output logic               o_drop
);
    logic [2:0]         w_b;
    logic [5:0]         w_off;
    logic [2*BLK_W-1:0] w_sh;
    entry_t             w_lo_mag;
    entry_t             w_hi_mag;
    entry_t             w_lo;
    entry_t             w_hi;

    assign w_b      = i_shift[8:6];
    assign w_off    = i_shift[5:0];
    assign w_sh     = {{BLK_W{1'b0}}, i_frac} << w_off;
    assign w_lo_mag = {{GUARD_W{1'b0}}, w_sh[BLK_W-1:0]};
    assign w_hi_mag = {{GUARD_W{1'b0}}, w_sh[2*BLK_W-1:BLK_W]};
    assign w_lo     = i_sign ? (ENTRY_W'(0) - w_lo_mag) : w_lo_mag;
    assign w_hi     = i_sign ? (ENTRY_W'(0) - w_hi_mag) : w_hi_mag;

    always_comb begin
        o_part_even = w_lo;
        o_part_odd  = w_hi;
        o_adr_even  = w_b[2:1];
        o_adr_odd   = w_b[2:1];
        o_en_even   = 1'b1;
        o_en_odd    = 1'b1;
        o_drop      = 1'b0;
        if (w_b[0]) begin
            o_part_odd  = w_lo;
            o_part_even = w_hi;
            o_adr_even  = w_b[2:1] + 2'd1;
            // block 7 has no block above it
            o_en_even   = (w_b != 3'd7);
            o_drop      = (w_b == 3'd7) && (w_hi_mag != '0);
        end
    end
endmodule

// File: rtl/quire_bank_writer.sv
// Write side of the banked quire: clear, pipelined read-modify-write
// accumulation with write forwarding, and completion signalling.
module quire_bank_writer
    import quire_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_sign,
    input  logic [BLK_W-1:0]   in_frac,
    input  logic [SHIFT_W-1:0] in_shift,
    input  logic               in_last,
    input  logic               clr,
    output badr_t              rd_adr_even,
    output badr_t              rd_adr_odd,
    input  entry_t             rd_data_even,
    input  entry_t             rd_data_odd,
    output logic               wr_en_even,
    output logic               wr_en_odd,
    output badr_t              wr_adr_even,
    output badr_t              wr_adr_odd,
    output entry_t             wr_data_even,
    output entry_t             wr_data_odd,
    output logic               acc_done,
    output logic               ovf
);
    localparam logic [CNT_W-1:0] CNT_SAT = '1;

    state_t           r_state, w_state_nx;
    logic [2:0]       r_clr_cnt;
    logic [CNT_W-1:0] r_acc_cnt;
    logic             r_ovf;

    logic   r_s0_vld, r_s0_en_e, r_s0_en_o;
    entry_t r_s0_part_e, r_s0_part_o;
    badr_t  r_s0_adr_e, r_s0_adr_o;
    logic   r_s1_vld, r_s1_en_e, r_s1_en_o;
    entry_t r_s1_part_e, r_s1_part_o;
    badr_t  r_s1_adr_e, r_s1_adr_o;
    logic   r_wr_en_e, r_wr_en_o;
    badr_t  r_wr_adr_e, r_wr_adr_o;
    entry_t r_wr_data_e, r_wr_data_o;
    logic   r_s4_en_e, r_s4_en_o;
    badr_t  r_s4_adr_e, r_s4_adr_o;
    entry_t r_s4_data_e, r_s4_data_o;

    entry_t w_part_e, w_part_o, w_old_e, w_old_o;
    badr_t  w_adr_e, w_adr_o;
    logic   w_en_e, w_en_o, w_drop;
    logic   w_accept, w_in_clr, w_clr_wr;

    quire_split u_split (
        .i_sign     (in_sign),
        .i_frac     (in_frac),
        .i_shift    (in_shift),
        .o_part_even(w_part_e),
        .o_part_odd (w_part_o),
        .o_adr_even (w_adr_e),
        .o_adr_odd  (w_adr_o),
        .o_en_even  (w_en_e),
        .o_en_odd   (w_en_o),
        .o_drop     (w_drop)
    );

    assign w_in_clr = (r_state == ST_CLEAR);
    assign w_clr_wr = w_in_clr && !r_clr_cnt[2];
    assign w_accept = in_valid && (r_state == ST_ACC);

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            ST_CLEAR: if (r_clr_cnt == 3'd4) w_state_nx = ST_ACC;
            ST_ACC:   if (w_accept && in_last) w_state_nx = ST_DRAIN;
            ST_DRAIN: if (!r_s0_vld && !r_s1_vld) w_state_nx = ST_DONE;
            ST_DONE:  if (clr) w_state_nx = ST_CLEAR;
            default:  w_state_nx = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
            r_acc_cnt <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_clr_cnt <= w_in_clr ? r_clr_cnt + 3'd1 : 3'd0;
            if (w_in_clr) begin
                r_acc_cnt <= '0;
                r_ovf     <= 1'b0;
            end else if (w_accept) begin
                if (r_acc_cnt != CNT_SAT) r_acc_cnt <= r_acc_cnt + 1'b1;
                if (w_drop || r_acc_cnt >= CNT_SAT - 1'b1) r_ovf <= 1'b1;
            end
        end
    end

    // newest in-flight write wins over the one just retired, then the bank
    always_comb begin
        w_old_e = rd_data_even;
        w_old_o = rd_data_odd;
        if (r_wr_en_e && r_wr_adr_e == r_s1_adr_e)      w_old_e = r_wr_data_e;
        else if (r_s4_en_e && r_s4_adr_e == r_s1_adr_e) w_old_e = r_s4_data_e;
        if (r_wr_en_o && r_wr_adr_o == r_s1_adr_o)      w_old_o = r_wr_data_o;
        else if (r_s4_en_o && r_s4_adr_o == r_s1_adr_o) w_old_o = r_s4_data_o;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s0_vld <= 1'b0; r_s0_en_e <= 1'b0; r_s0_en_o <= 1'b0;
            r_s0_part_e <= '0; r_s0_part_o <= '0;
            r_s0_adr_e <= '0; r_s0_adr_o <= '0;
            r_s1_vld <= 1'b0; r_s1_en_e <= 1'b0; r_s1_en_o <= 1'b0;
            r_s1_part_e <= '0; r_s1_part_o <= '0;
            r_s1_adr_e <= '0; r_s1_adr_o <= '0;
            r_wr_en_e <= 1'b0; r_wr_en_o <= 1'b0;
            r_wr_adr_e <= '0; r_wr_adr_o <= '0;
            r_wr_data_e <= '0; r_wr_data_o <= '0;
            r_s4_en_e <= 1'b0; r_s4_en_o <= 1'b0;
            r_s4_adr_e <= '0; r_s4_adr_o <= '0;
            r_s4_data_e <= '0; r_s4_data_o <= '0;
        end else begin
            r_s0_vld <= w_accept;
            if (w_accept) begin
                r_s0_en_e <= w_en_e; r_s0_en_o <= w_en_o;
                r_s0_part_e <= w_part_e; r_s0_part_o <= w_part_o;
                r_s0_adr_e <= w_adr_e; r_s0_adr_o <= w_adr_o;
            end
            r_s1_vld <= r_s0_vld && !w_in_clr;
            r_s1_en_e <= r_s0_en_e; r_s1_en_o <= r_s0_en_o;
            r_s1_part_e <= r_s0_part_e; r_s1_part_o <= r_s0_part_o;
            r_s1_adr_e <= r_s0_adr_e; r_s1_adr_o <= r_s0_adr_o;
            if (w_clr_wr) begin
                r_wr_en_e <= 1'b1; r_wr_en_o <= 1'b1;
                r_wr_adr_e <= r_clr_cnt[1:0]; r_wr_adr_o <= r_clr_cnt[1:0];
                r_wr_data_e <= '0; r_wr_data_o <= '0;
            end else begin
                r_wr_en_e <= r_s1_vld && r_s1_en_e && !w_in_clr;
                r_wr_en_o <= r_s1_vld && r_s1_en_o && !w_in_clr;
                r_wr_adr_e <= r_s1_adr_e; r_wr_adr_o <= r_s1_adr_o;
                r_wr_data_e <= w_old_e + r_s1_part_e;
                r_wr_data_o <= w_old_o + r_s1_part_o;
            end
            r_s4_en_e <= r_wr_en_e; r_s4_en_o <= r_wr_en_o;
            r_s4_adr_e <= r_wr_adr_e; r_s4_adr_o <= r_wr_adr_o;
            r_s4_data_e <= r_wr_data_e; r_s4_data_o <= r_wr_data_o;
        end
    end

    assign in_ready     = (r_state == ST_ACC);
    assign acc_done     = (r_state == ST_DONE);
    assign ovf          = r_ovf;
    assign rd_adr_even  = r_s0_adr_e;
    assign rd_adr_odd   = r_s0_adr_o;
    assign wr_en_even   = r_wr_en_e;
    assign wr_en_odd    = r_wr_en_o;
    assign wr_adr_even  = r_wr_adr_e;
    assign wr_adr_odd   = r_wr_adr_o;
    assign wr_data_even = r_wr_data_e;
    assign wr_data_odd  = r_wr_data_o;
endmodule
